fir_hls_sdiv_28s_12s_16_seq: RTL and testbench



---
 rtl/fir_hls_sdiv_28s_12s_16_seq_if.sv | 28 ++
 rtl/fir_hls_sdiv_28s_12s_16_seq.sv | 141 ++++++++++++++
 tb/tb_fir_hls_sdiv_28s_12s_16_seq.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fir_hls_sdiv_28s_12s_16_seq_if.sv
// Operand/result handshake bundle for the sequential signed divider.
// master = producer of operands / consumer of results; slave = divider.
interface fir_hls_sdiv_28s_12s_16_seq_if #(
    parameter int DIVIDEND_W = 28,
    parameter int DIVISOR_W  = 12,
    parameter int QUOT_W     = 16
);
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DIVIDEND_W-1:0] dividend;
    logic signed [DIVISOR_W-1:0]  divisor;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [QUOT_W-1:0]     quotient;
    logic signed [DIVISOR_W-1:0]  remainder;
    logic                         ovf;
    logic                         dbz;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, ovf, dbz
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, ovf, dbz
    );
endinterface

// File: rtl/fir_hls_sdiv_28s_12s_16_seq.sv
// Radix-2 restoring signed divider: 28s / 12s -> 16s saturated quotient,
// 12s remainder (sign of dividend), overflow and divide-by-zero flags.
// One operation in flight; fixed 29-cycle latency, 31-cycle initiation interval.
module fir_hls_sdiv_28s_12s_16_seq #(
    parameter int DIVIDEND_W = 28,
    parameter int DIVISOR_W  = 12,
    parameter int QUOT_W     = 16
) (
    input  logic                            ap_clk,
    input  logic                            ap_rst_n,
    fir_hls_sdiv_28s_12s_16_seq_if.slave    bus
);
    localparam int CNT_W = $clog2(DIVIDEND_W);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DIVIDEND_W - 1);
    localparam logic [DIVIDEND_W-1:0] QPOS_LIM = DIVIDEND_W'((2 ** (QUOT_W - 1)) - 1);
    localparam logic [DIVIDEND_W-1:0] QNEG_LIM = DIVIDEND_W'(2 ** (QUOT_W - 1));
    localparam logic [QUOT_W-1:0]     QMAX     = {1'b0, {(QUOT_W-1){1'b1}}};
    localparam logic [QUOT_W-1:0]     QMIN     = {1'b1, {(QUOT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [DIVIDEND_W-1:0]   dq;        // dividend magnitude shifts out, quotient bits shift in
    logic [DIVISOR_W-1:0]    prem;      // partial remainder, always < divisor magnitude
    logic [DIVISOR_W-1:0]    dmag;
    logic                    sign_q;
    logic                    sign_r;
    logic                    dbz_flag;

    logic                    in_ready_r;
    logic                    out_valid_r;
    logic [QUOT_W-1:0]       quot_r;
    logic [DIVISOR_W-1:0]    rem_r;
    logic                    ovf_r;
    logic                    dbz_r;

    logic [DIVIDEND_W-1:0]   a_mag;
    logic [DIVISOR_W-1:0]    b_mag;
    logic [DIVISOR_W:0]      shifted;
    logic [DIVISOR_W-1:0]    diff;
    logic                    take;
    logic [QUOT_W-1:0]       q_neg;
    logic [DIVISOR_W-1:0]    r_neg;

    // Operand magnitudes, one restoring step, and the negated result candidates.
    always_comb begin
        a_mag   = bus.dividend[DIVIDEND_W-1] ? (~bus.dividend + 1'b1) : bus.dividend;
        b_mag   = bus.divisor[DIVISOR_W-1]   ? (~bus.divisor + 1'b1)  : bus.divisor;
        shifted = {prem, dq[DIVIDEND_W-1]};
        take    = shifted >= {1'b0, dmag};
        // When take is set the difference is below dmag, so the low bits are exact.
        diff    = shifted[DIVISOR_W-1:0] - dmag;
        q_neg   = ~dq[QUOT_W-1:0] + 1'b1;
        r_neg   = ~prem + 1'b1;
    end

    // Control FSM with datapath and registered outputs.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            dq          <= '0;
            prem        <= '0;
            dmag        <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            dbz_flag    <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            quot_r      <= '0;
            rem_r       <= '0;
            ovf_r       <= 1'b0;
            dbz_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_ready_r && bus.in_valid) begin
                        dq         <= a_mag;
                        dmag       <= b_mag;
                        prem       <= '0;
                        sign_q     <= bus.dividend[DIVIDEND_W-1] ^ bus.divisor[DIVISOR_W-1];
                        sign_r     <= bus.dividend[DIVIDEND_W-1];
                        dbz_flag   <= (bus.divisor == '0);
                        cnt        <= '0;
                        in_ready_r <= 1'b0;
                        state      <= CALC;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                CALC: begin
                    prem <= take ? diff : shifted[DIVISOR_W-1:0];
                    dq   <= {dq[DIVIDEND_W-2:0], take};
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (dbz_flag) begin
                        quot_r <= sign_r ? QMIN : QMAX;
                        rem_r  <= '0;
                        ovf_r  <= 1'b0;
                        dbz_r  <= 1'b1;
                    end else begin
                        rem_r <= sign_r ? r_neg : prem;
                        dbz_r <= 1'b0;
                        if (!sign_q && (dq > QPOS_LIM)) begin
                            quot_r <= QMAX;
                            ovf_r  <= 1'b1;
                        end else if (sign_q && (dq > QNEG_LIM)) begin
                            quot_r <= QMIN;
                            ovf_r  <= 1'b1;
                        end else begin
                            quot_r <= sign_q ? q_neg : dq[QUOT_W-1:0];
                            ovf_r  <= 1'b0;
                        end
                    end
                    out_valid_r <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.quotient  = quot_r;
    assign bus.remainder = rem_r;
    assign bus.ovf       = ovf_r;
    assign bus.dbz       = dbz_r;
endmodule

// File: tb/tb_fir_hls_sdiv_28s_12s_16_seq.sv
// Self-checking bench for the sequential signed divider: directed sign,
// overflow, divide-by-zero, backpressure and reset cases, then randomized
// operands against a C-semantics truncating-divide reference.
module tb_fir_hls_sdiv_28s_12s_16_seq;
    logic ap_clk   = 1'b0;
    logic ap_rst_n = 1'b0;
    int   cyc      = 0;
    int   vectors  = 0;
    int   miscompares = 0;

    fir_hls_sdiv_28s_12s_16_seq_if #(.DIVIDEND_W(28), .DIVISOR_W(12), .QUOT_W(16)) bus ();

    fir_hls_sdiv_28s_12s_16_seq #(.DIVIDEND_W(28), .DIVISOR_W(12), .QUOT_W(16)) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus.slave)
    );

    always #5 ap_clk = ~ap_clk;

    // Edge counter used to measure latency.
    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // Truncating divide with 16-bit saturation; zero divisor saturates by dividend sign.
    function automatic void model(input longint a, input longint b,
                                  output longint q, output longint r,
                                  output longint ov, output longint dz);
        longint t;
        if (b == 0) begin
            q = (a >= 0) ? 32767 : -32768;
            r = 0; ov = 0; dz = 1;
        end else begin
            t = a / b;
            r = a % b;
            dz = 0; ov = 0; q = t;
            if (t > 32767) begin
                q = 32767; ov = 1;
            end else if (t < -32768) begin
                q = -32768; ov = 1;
            end
        end
    endfunction

    task automatic send(input longint a, input longint b, output int t_acc);
        int n;
        logic [31:0] junk;
        n = 0;
        bus.dividend = a[27:0];
        bus.divisor  = b[11:0];
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!bus.in_ready) check("accept_timeout", 0, 1);
        tick();
        t_acc = cyc;
        bus.in_valid = 1'b0;
        // Scramble operands after acceptance; the captured values must be unaffected.
        junk = $urandom;
        bus.dividend = junk[27:0];
        bus.divisor  = junk[31:20];
    endtask

    task automatic recv(input int t_acc, input longint q, input longint r,
                        input longint ov, input longint dz, input int stall);
        int n;
        logic [31:0] junk;
        n = 0;
        bus.out_ready = (stall == 0);
        while (!bus.out_valid && n < 100) begin
            tick();
            n++;
        end
        check("out_valid_seen", longint'(bus.out_valid), 1);
        check("latency", longint'(cyc - t_acc), 29);
        check("quotient", longint'(bus.quotient), q);
        check("remainder", longint'(bus.remainder), r);
        check("ovf", longint'(bus.ovf), ov);
        check("dbz", longint'(bus.dbz), dz);
        for (int i = 0; i < stall; i++) begin
            junk = $urandom;
            bus.in_valid = 1'b1;
            bus.dividend = junk[27:0];
            bus.divisor  = junk[31:20];
            tick();
            check("stall_valid", longint'(bus.out_valid), 1);
            check("stall_in_ready", longint'(bus.in_ready), 0);
            check("stall_quotient", longint'(bus.quotient), q);
            check("stall_remainder", longint'(bus.remainder), r);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("consumed", longint'(bus.out_valid), 0);
        check("ready_after", longint'(bus.in_ready), 1);
        check("held_quotient", longint'(bus.quotient), q);
    endtask

    task automatic run_op(input longint a, input longint b, input int stall);
        int t;
        longint q, r, ov, dz;
        model(a, b, q, r, ov, dz);
        send(a, b, t);
        recv(t, q, r, ov, dz, stall);
    endtask

    // Assert reset between edges, check asynchronous clearing, release, check ready timing.
    task automatic reset_pulse(input string tag);
        ap_rst_n = 1'b0;
        #1;
        check({tag, "_out_valid"}, longint'(bus.out_valid), 0);
        check({tag, "_in_ready"}, longint'(bus.in_ready), 0);
        check({tag, "_quotient"}, longint'(bus.quotient), 0);
        check({tag, "_remainder"}, longint'(bus.remainder), 0);
        check({tag, "_ovf"}, longint'(bus.ovf), 0);
        check({tag, "_dbz"}, longint'(bus.dbz), 0);
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        #1;
        check({tag, "_ready_pre_edge"}, longint'(bus.in_ready), 0);
        tick();
        check({tag, "_ready_post_edge"}, longint'(bus.in_ready), 1);
    endtask

    longint dir_a [12] = '{1000, -1000, 1000, 100000, 134217727, -134217728,
                           65536, -65536, 5, -5, 0, -1};
    longint dir_b [12] = '{7, 7, -7, -3, -2048, -1, 2, 2, 0, 0, 0, 2047};

    initial begin
        int t;
        int n;
        longint a, b;
        logic signed [27:0] ra;
        logic signed [11:0] rb;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        #2;
        check("rst_in_ready", longint'(bus.in_ready), 0);
        check("rst_out_valid", longint'(bus.out_valid), 0);
        check("rst_quotient", longint'(bus.quotient), 0);
        #21;
        ap_rst_n = 1'b1;
        tick();
        check("ready_after_release", longint'(bus.in_ready), 1);

        // Literal values for the first case guard the reference itself.
        send(1000, 7, t);
        recv(t, 142, 6, 0, 0, 0);

        for (int i = 0; i < 12; i++) run_op(dir_a[i], dir_b[i], 0);

        // Backpressure: result held 10 cycles with in_valid asserted.
        run_op(-30000, 9, 10);

        // Reset mid-CALC: the previous result (nonzero) must clear immediately.
        run_op(12345, 11, 0);
        send(99999, 13, t);
        repeat (11) tick();
        reset_pulse("rst_calc");
        run_op(2047, -1, 0);

        // Reset while holding a result in DONE.
        bus.out_ready = 1'b0;
        send(-777, 5, t);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            tick();
            n++;
        end
        check("done_reached", longint'(bus.out_valid), 1);
        reset_pulse("rst_done");
        run_op(-2048, 2047, 0);

        // Randomized regression with random output stalls.
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 2))
                0: begin ra = 28'($urandom); a = longint'(ra); end
                1: a = longint'($urandom_range(0, 200000)) - 100000;
                default: a = longint'($urandom_range(0, 4000)) - 2000;
            endcase
            case ($urandom_range(0, 7))
                0: b = 0;
                1, 2: b = longint'($urandom_range(0, 20)) - 10;
                default: begin rb = 12'($urandom); b = longint'(rb); end
            endcase
            run_op(a, b, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
